bitwise_logic_pipe: RTL

//   Parametrised, pipelined bitwise logic unit for the ALU datapath; the next generation of the

---
 rtl/bitwise_logic_pipe_if.sv | 35 +++
 rtl/bitwise_logic_pipe.sv | 98 +++++++++
 2 files changed

// File: rtl/bitwise_logic_pipe_if.sv
// rtl/bitwise_logic_pipe_if.sv - operand/result handshake bundle for bitwise_logic_pipe
//
// Purpose: groups the input beat channel and the result channel of the
// bitwise logic pipe into one port.
// Signals:
//   in_valid/in_ready      input beat handshake
//   in_op/in_a/in_b        function select and operands
//   in_last                final beat of an ACC_OR sequence
//   out_valid/out_ready    result handshake
//   out_data/out_zero      result and its all-zero flag
// Modports: master drives beats and out_ready; slave is the logic unit.
interface bitwise_logic_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  modport master (
    output in_valid, in_op, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );
endinterface

// File: rtl/bitwise_logic_pipe.sv
// rtl/bitwise_logic_pipe.sv - pipelined bitwise logic unit with OR-accumulate
//
// Purpose: computes one of eight bitwise functions of a and b (or an
// OR-fold over a multi-beat ACC_OR sequence) and delivers the result
// STAGES cycles after acceptance.
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous active-high, clears all state
//   bus    bitwise_logic_pipe_if.slave: in_* beat channel, out_* result channel
// Parameters:
//   WIDTH   operand/result width (must match the interface WIDTH)
//   STAGES  cycles from accepted beat to out_valid (1..4)
module bitwise_logic_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  bitwise_logic_pipe_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_AND    = 3'b000,
    OP_OR     = 3'b001,
    OP_XOR    = 3'b010,
    OP_NOR    = 3'b011,
    OP_NAND   = 3'b100,
    OP_XNOR   = 3'b101,
    OP_ANDN   = 3'b110,
    OP_ACC_OR = 3'b111
  } op_e;

  op_e              op;
  logic             advance;
  logic             accept;
  logic             s1_load;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] func_res;

  logic             stage_valid [STAGES];
  logic [WIDTH-1:0] stage_data  [STAGES];
  logic             stage_zero  [STAGES];

  assign op = op_e'(bus.in_op);

  // The whole pipe moves as one; a stalled output freezes every stage,
  // so bubbles are never squeezed out.
  assign advance      = !stage_valid[STAGES-1] || bus.out_ready;
  assign bus.in_ready = advance;
  assign accept       = bus.in_valid && advance;

  always_comb begin
    func_res = '0;
    case (op)
      OP_AND:    func_res = bus.in_a & bus.in_b;
      OP_OR:     func_res = bus.in_a | bus.in_b;
      OP_XOR:    func_res = bus.in_a ^ bus.in_b;
      OP_NOR:    func_res = ~(bus.in_a | bus.in_b);
      OP_NAND:   func_res = ~(bus.in_a & bus.in_b);
      OP_XNOR:   func_res = ~(bus.in_a ^ bus.in_b);
      OP_ANDN:   func_res = bus.in_a & ~bus.in_b;
      OP_ACC_OR: func_res = acc | bus.in_a | bus.in_b;
      default:   func_res = '0;
    endcase
  end

  // Non-final ACC_OR beats only fold into acc; stage 1 takes a bubble.
  assign s1_load = accept && ((op != OP_ACC_OR) || bus.in_last);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc <= '0;
      for (int k = 0; k < STAGES; k++) begin
        stage_valid[k] <= 1'b0;
        stage_data[k]  <= '0;
        stage_zero[k]  <= 1'b0;
      end
    end else if (advance) begin
      stage_valid[0] <= s1_load;
      stage_data[0]  <= s1_load ? func_res : '0;
      stage_zero[0]  <= s1_load && (func_res == '0);
      for (int k = 1; k < STAGES; k++) begin
        stage_valid[k] <= stage_valid[k-1];
        stage_data[k]  <= stage_data[k-1];
        stage_zero[k]  <= stage_zero[k-1];
      end
      // acc is touched only by accepted ACC_OR beats; other ops leave it alone.
      if (accept && (op == OP_ACC_OR)) begin
        acc <= bus.in_last ? '0 : (acc | bus.in_a | bus.in_b);
      end
    end
  end

  assign bus.out_valid = stage_valid[STAGES-1];
  assign bus.out_data  = stage_data[STAGES-1];
  assign bus.out_zero  = stage_zero[STAGES-1];

endmodule
